// File: rtl/session_pkg.sv
// Shared types and constants for the session reporter: FSM state encoding,
// default report header and report frame length.
package session_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam logic [7:0] REPORT_HDR = 8'hA5;

   // Header + event counter bytes + cycle counter bytes + checksum
   function automatic int frame_len(input int evt_w, input int cyc_w);
      return 2 + evt_w / 8 + cyc_w / 8;
   endfunction

endpackage

// File: rtl/session_reporter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + 1'b1;
   end

endmodule

// File: rtl/session_reporter.sv
// Measures a start/working/stop session (event strobes and working cycles) and,
// on stop, streams a checksummed report over a byte valid/ready interface.
module session_reporter
   import session_pkg::*;
#(
   parameter int         EVT_W = 32,
   parameter int         CYC_W = 32,
   parameter logic [7:0] HDR   = REPORT_HDR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       working,
   input  logic       stop,
   input  logic       evt,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       seq_err
);

   localparam int N     = frame_len(EVT_W, CYC_W);
   localparam int IDX_W = $clog2(N);
   localparam int PW    = EVT_W + CYC_W;

   localparam logic [IDX_W-1:0] LAST     = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] LAST_PAY = IDX_W'(N - 2);

   state_t state, state_nx;

   logic             cnt_clr, evt_inc, cyc_inc;
   logic [EVT_W-1:0] evt_q;
   logic [CYC_W-1:0] cyc_q;
   logic [PW-1:0]    shadow;
   logic [IDX_W-1:0] idx;
   logic [7:0]       chk;
   logic             accept, last;

   sat_counter #(.W(EVT_W)) u_evt_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (evt_inc),
      .q     (evt_q)
   );

   sat_counter #(.W(CYC_W)) u_cyc_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cyc_inc),
      .q     (cyc_q)
   );

   assign accept = tx_valid & tx_ready;
   assign last   = (idx == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // A start in RUN restarts the session and discards that cycle's strobes
   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      evt_inc  = 1'b0;
      cyc_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               cnt_clr  = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (start) begin
               cnt_clr = 1'b1;
            end else begin
               evt_inc = evt;
               cyc_inc = working;
               if (stop)
                  state_nx = SEND;
            end
         end
         SEND: begin
            if (accept && last)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         seq_err <= 1'b0;
      end else begin
         busy <= (state_nx != IDLE);
         done <= (state == SEND) && accept && last;
         if ((state == IDLE) && start)
            seq_err <= 1'b0;
         else if (((state == IDLE) && stop) ||
                  ((state == RUN) && start) ||
                  ((state == SEND) && (start || stop)))
            seq_err <= 1'b1;
      end
   end

   // First SEND cycle (tx_valid still low) snapshots the counters and presents
   // the header; the shadow then shifts out MSB-first, one byte per accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data  <= '0;
         tx_valid <= 1'b0;
         shadow   <= '0;
         idx      <= '0;
         chk      <= '0;
      end else if (state == SEND) begin
         if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= HDR;
            chk      <= HDR;
            shadow   <= {evt_q, cyc_q};
            idx      <= '0;
         end else if (accept) begin
            if (last) begin
               tx_valid <= 1'b0;
            end else begin
               idx <= idx + 1'b1;
               if (idx == LAST_PAY) begin
                  tx_data <= chk;
               end else begin
                  tx_data <= shadow[PW-1 -: 8];
                  chk     <= chk ^ shadow[PW-1 -: 8];
                  shadow  <= shadow << 8;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_session_reporter.sv
// Randomized self-checking bench for session_reporter; expected frames come from
// plain session counts, saturated and serialised arithmetically.
module tb_session_reporter;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, working = 1'b0, stop = 1'b0, evt = 1'b0;
   logic       tx_ready = 1'b0, tx_ready8 = 1'b0;
   logic [7:0] tx_data, tx_data8;
   logic       tx_valid, busy, done, seq_err;
   logic       tx_valid8, busy8, done8, seq_err8;

   int     n_vec = 0;
   int     n_err = 0;
   longint m_evt, m_cyc;

   always #5 clk = ~clk;

   session_reporter dut (
      .clk(clk), .reset(reset), .start(start), .working(working), .stop(stop), .evt(evt),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .seq_err(seq_err)
   );

   session_reporter #(.EVT_W(8), .CYC_W(8)) dut8 (
      .clk(clk), .reset(reset), .start(start), .working(working), .stop(stop), .evt(evt),
      .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
      .busy(busy8), .done(done8), .seq_err(seq_err8)
   );

   function automatic bq_t build_frame(input longint e, input longint c, input int ew, input int cw);
      bq_t        q;
      logic [7:0] x;
      longint     emax, cmax;
      emax = (longint'(1) << ew) - 1;
      cmax = (longint'(1) << cw) - 1;
      if (e > emax) e = emax;
      if (c > cmax) c = cmax;
      q.push_back(8'hA5);
      for (int i = ew / 8 - 1; i >= 0; i--) q.push_back(8'((e >> (8 * i)) & 255));
      for (int i = cw / 8 - 1; i >= 0; i--) q.push_back(8'((c >> (8 * i)) & 255));
      x = 8'h00;
      foreach (q[i]) x = x ^ q[i];
      q.push_back(x);
      return q;
   endfunction

   task automatic begin_session();
      start   = 1'b1;
      working = 1'($urandom_range(0, 1));
      evt     = 1'($urandom_range(0, 1));
      m_evt   = 0;
      m_cyc   = 0;
      @(negedge clk);
      start = 1'b0; working = 1'b0; evt = 1'b0;
   endtask

   task automatic run_cycles(input int n, input int pe, input int pw);
      for (int i = 0; i < n; i++) begin
         evt     = ($urandom_range(0, 99) < pe);
         working = ($urandom_range(0, 99) < pw);
         if (evt) m_evt++;
         if (working) m_cyc++;
         @(negedge clk);
      end
      evt = 1'b0; working = 1'b0;
   endtask

   task automatic end_session(input bit act);
      stop = 1'b1;
      if (act) begin
         evt     = 1'($urandom_range(0, 1));
         working = 1'($urandom_range(0, 1));
         if (evt) m_evt++;
         if (working) m_cyc++;
      end
      @(negedge clk);
      stop = 1'b0; evt = 1'b0; working = 1'b0;
   endtask

   // Drains one frame from the main DUT; mode 0 ready=1, 1 pattern 1,0,0, 2 random.
   // inj>=0 pulses start then stop while the frame is in flight.
   task automatic recv_check(input bq_t exp, input string name, input int mode, input int inj);
      int         k = 0, cnt = 0;
      logic       stalled = 1'b0;
      logic [7:0] prev = 8'h00;
      while (k < exp.size() && cnt < 400) begin
         if (stalled) begin
            n_vec++;
            if (tx_data !== prev) begin
               n_err++;
               $display("FAIL %s stall_hold: got %h want %h", name, tx_data, prev);
            end
         end
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cnt % 3 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         start = (inj >= 0) && (cnt == inj);
         stop  = (inj >= 0) && (cnt == inj + 1);
         if (tx_valid && tx_ready) begin
            n_vec++;
            if (tx_data !== exp[k]) begin
               n_err++;
               $display("FAIL %s byte%0d: got %h want %h", name, k, tx_data, exp[k]);
            end
            k++;
         end
         stalled = tx_valid && !tx_ready;
         prev    = tx_data;
         cnt++;
         @(negedge clk);
      end
      start = 1'b0; stop = 1'b0; tx_ready = 1'b0;
      n_vec++;
      if (k != exp.size()) begin
         n_err++;
         $display("FAIL %s byte_count: got %0d want %0d", name, k, exp.size());
      end
      n_vec++;
      if ({done, tx_valid, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL %s end_state{done,valid,busy}: got %b want 100", name, {done, tx_valid, busy});
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL %s done_pulse_width: got %b want 0", name, done);
      end
   endtask

   task automatic spec1_stim();
      begin_session();
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL busy_after_start: got %b want 1", busy);
      end
      for (int i = 0; i < 5; i++) begin
         working = 1'b1;
         evt     = (i % 2 == 0);
         @(negedge clk);
      end
      working = 1'b0; evt = 1'b0;
      end_session(1'b0);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++;
      if ({tx_data, tx_valid, busy, done, seq_err} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_state: got %h want 000", {tx_data, tx_valid, busy, done, seq_err});
      end
      n_vec++;
      if ({tx_data8, tx_valid8, busy8, done8, seq_err8} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_state8: got %h want 000", {tx_data8, tx_valid8, busy8, done8, seq_err8});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bq_t exp;
      exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'hA3};
      spec1_stim();
      recv_check(exp, "basic", 0, -1);
   endtask

   task automatic test_stall();
      bq_t exp;
      exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'hA3};
      spec1_stim();
      recv_check(exp, "stall", 1, -1);
   endtask

   task automatic test_saturate();
      bq_t exp8;
      int  k = 0;
      tx_ready8 = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      begin_session();
      for (int i = 0; i < 300; i++) begin
         working = 1'b1; evt = 1'b1;
         m_evt++; m_cyc++;
         @(negedge clk);
      end
      working = 1'b0; evt = 1'b0;
      end_session(1'b0);
      recv_check(build_frame(m_evt, m_cyc, 32, 32), "sat_wide", 0, -1);
      exp8 = build_frame(m_evt, m_cyc, 8, 8);
      tx_ready8 = 1'b1;
      for (int c = 0; c < 20 && k < exp8.size(); c++) begin
         if (tx_valid8) begin
            n_vec++;
            if (tx_data8 !== exp8[k]) begin
               n_err++;
               $display("FAIL sat8 byte%0d: got %h want %h", k, tx_data8, exp8[k]);
            end
            k++;
         end
         @(negedge clk);
      end
      tx_ready8 = 1'b0;
      n_vec++;
      if (k != exp8.size()) begin
         n_err++;
         $display("FAIL sat8 byte_count: got %0d want %0d", k, exp8.size());
      end
   endtask

   task automatic test_seq_err();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n_vec++;
      if (seq_err !== 1'b1) begin
         n_err++;
         $display("FAIL idle_stop_seq_err: got %b want 1", seq_err);
      end
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if ({tx_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_stop_quiet{valid,busy}: got %b want 00", {tx_valid, busy});
         end
      end
      begin_session();
      n_vec++;
      if ({seq_err, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL start_clears{seq_err,busy}: got %b want 01", {seq_err, busy});
      end
      run_cycles(8, 50, 50);
      end_session(1'b1);
      recv_check(build_frame(m_evt, m_cyc, 32, 32), "after_err", 2, -1);
   endtask

   task automatic test_restart();
      begin_session();
      for (int i = 0; i < 4; i++) begin
         evt = 1'b1; working = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      start = 1'b1; evt = 1'b1; working = 1'b1;
      m_evt = 0; m_cyc = 0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         evt = 1'b1; working = 1'b1;
         m_evt++; m_cyc++;
         @(negedge clk);
      end
      evt = 1'b0; working = 1'b0;
      end_session(1'b0);
      n_vec++;
      if (seq_err !== 1'b1) begin
         n_err++;
         $display("FAIL restart_seq_err: got %b want 1", seq_err);
      end
      recv_check(build_frame(m_evt, m_cyc, 32, 32), "restart", 0, 2);
      n_vec++;
      if (seq_err !== 1'b1) begin
         n_err++;
         $display("FAIL send_start_seq_err: got %b want 1", seq_err);
      end
   endtask

   task automatic test_reset_mid_send();
      int  k = 0;
      bit  hit = 0;
      begin_session();
      run_cycles(10, 50, 50);
      end_session(1'b1);
      tx_ready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (k == 3 && tx_valid) begin
            hit = 1;
            break;
         end
         if (tx_valid) k++;
         @(negedge clk);
      end
      n_vec++;
      if (!hit) begin
         n_err++;
         $display("FAIL midsend_reach_byte4: got %0d bytes want 3 then valid", k);
      end
      tx_ready = 1'b0;
      reset = 1'b1;
      #1;
      n_vec++;
      if ({tx_valid, busy, done, seq_err} !== 4'b0000) begin
         n_err++;
         $display("FAIL midsend_reset{valid,busy,done,err}: got %b want 0000", {tx_valid, busy, done, seq_err});
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if (tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midsend_no_resume: got %b want 0", tx_valid);
         end
      end
      begin_session();
      run_cycles(12, 40, 70);
      end_session(1'b1);
      recv_check(build_frame(m_evt, m_cyc, 32, 32), "post_reset", 2, -1);
      n_vec++;
      if (seq_err !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_seq_err: got %b want 0", seq_err);
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 15; s++) begin
         begin_session();
         run_cycles($urandom_range(0, 40), $urandom_range(0, 100), $urandom_range(0, 100));
         end_session(1'b1);
         recv_check(build_frame(m_evt, m_cyc, 32, 32), "random", 2, -1);
         n_vec++;
         if (seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL random_seq_err: got %b want 0", seq_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_saturate();
      test_seq_err();
      test_restart();
      test_reset_mid_send();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
